sp_ram_arb: RTL and testbench

Round-robin access controller that shares one single-port RAM (registered address/data/write-enable inputs, registered read data, 2-cycle read latency) between `NREQ` requesters. Each requester issues read or write commands over a valid/ready handshake. The block grants at most one command per cycle, drives the RAM port directly, and returns read data to the originating requester with a one-hot response strobe. It sits between client logic (packet buffers, table walkers) and the RAM instance.

---
 rtl/sp_ram_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/sp_ram_arb.sv | 125 ++++++++++++
 tb/tb_sp_ram_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_arb_pkg.sv
// Shared types and constants for the single-port RAM round-robin access controller.
package sp_ram_arb_pkg;

    localparam int unsigned RD_LATENCY = 2;

    typedef enum logic [0:0] {
        ST_INIT,
        ST_RUN
    } arb_state_e;

    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
    } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: combinational grant, registered search pointer.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         gnt_o,
    output logic                 gnt_vld_o,
    output logic [$clog2(N)-1:0] gnt_idx_o
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] ptr_q, ptr_d, idx;

    // Search starts at ptr_q and wraps; first requester found wins.
    always_comb begin
        gnt_o     = '0;
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        idx       = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = IW'((32'(ptr_q) + off) % N);
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o  = 1'b1;
                gnt_idx_o  = idx;
                gnt_o[idx] = 1'b1;
            end
        end
        ptr_d = gnt_vld_o ? IW'((32'(gnt_idx_o) + 1) % N) : ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sp_ram_arb.sv
// Round-robin access controller sharing one single-port RAM between NREQ requesters.
// Optional SP_RAM_ARB_INIT_EN adds a zero-fill walk of the whole RAM after reset.
module sp_ram_arb
    import sp_ram_arb_pkg::*;
#(
    parameter int unsigned AW   = 12,
    parameter int unsigned DW   = 82,
    parameter int unsigned NREQ = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ-1:0][AW-1:0]  req_addr,
    input  logic [NREQ-1:0][DW-1:0]  req_wdata,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DW-1:0]            rsp_rdata,
    output logic                     ram_we,
    output logic [AW-1:0]            ram_addr,
    output logic [DW-1:0]            ram_din,
    input  logic [DW-1:0]            ram_dout,
    output logic                     init_done
);

    localparam int unsigned IW = $clog2(NREQ);

`ifdef SP_RAM_ARB_INIT_EN
    localparam arb_state_e StReset = ST_INIT;
`else
    localparam arb_state_e StReset = ST_RUN;
`endif

    arb_state_e                  st_q, st_d;
    logic                        run;
    logic [NREQ-1:0]             gnt;
    logic                        gnt_vld;
    logic [IW-1:0]               gnt_idx;
    logic [AW-1:0]               addr_q;
    logic [DW-1:0]               din_q;
    rd_tag_t [RD_LATENCY-1:0]    pipe_q;
    rd_tag_t                     tag_in;
`ifdef SP_RAM_ARB_INIT_EN
    logic [AW-1:0]               cnt_q, cnt_d;
`endif

    // Reset masks requests combinationally so nothing is granted in the reset cycle.
    assign run       = (st_q == ST_RUN) && !rst;
    assign init_done = run;
    assign rsp_rdata = ram_dout;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req_valid & {NREQ{run}}),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        st_d      = st_q;
        req_ready = gnt;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_din   = din_q;
        tag_in    = '0;
`ifdef SP_RAM_ARB_INIT_EN
        cnt_d     = cnt_q;
`endif
        if (rst) begin
            ram_addr = '0;
            ram_din  = '0;
        end else if (st_q == ST_INIT) begin
`ifdef SP_RAM_ARB_INIT_EN
            ram_we   = 1'b1;
            ram_addr = cnt_q;
            ram_din  = '0;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == {AW{1'b1}}) begin
                st_d = ST_RUN;
            end
`endif
        end else if (gnt_vld) begin
            ram_we     = req_we[gnt_idx];
            ram_addr   = req_addr[gnt_idx];
            ram_din    = req_wdata[gnt_idx];
            tag_in.vld = !req_we[gnt_idx];
            tag_in.idx = 3'(gnt_idx);
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = !rst && pipe_q[RD_LATENCY-1].vld
                           && (pipe_q[RD_LATENCY-1].idx == 3'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= StReset;
            addr_q <= '0;
            din_q  <= '0;
            pipe_q <= '0;
`ifdef SP_RAM_ARB_INIT_EN
            cnt_q  <= '0;
`endif
        end else begin
            st_q   <= st_d;
            pipe_q <= {pipe_q[RD_LATENCY-2:0], tag_in};
            if (gnt_vld) begin
                addr_q <= ram_addr;
                din_q  <= ram_din;
            end
`ifdef SP_RAM_ARB_INIT_EN
            cnt_q  <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_sp_ram_arb.sv
// Scoreboard bench for sp_ram_arb: behavioural RAM, round-robin reference, response queue.
module tb_sp_ram_arb;

    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 82;
    localparam int unsigned NREQ  = 2;
    localparam int          DEPTH = 1 << AW;

    logic                    clk;
    logic                    rst;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0]         req_we;
    logic [NREQ-1:0][AW-1:0] req_addr;
    logic [NREQ-1:0][DW-1:0] req_wdata;
    logic [NREQ-1:0]         rsp_valid;
    logic [DW-1:0]           rsp_rdata;
    logic                    ram_we;
    logic [AW-1:0]           ram_addr;
    logic [DW-1:0]           ram_din;
    logic [DW-1:0]           ram_dout;
    logic                    init_done;

    sp_ram_arb #(
        .AW   (AW),
        .DW   (DW),
        .NREQ (NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: registered inputs, registered read data (2-cycle read).
    logic [DW-1:0] mem [DEPTH];
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din, m_dout;
    always @(posedge clk) begin
        m_we   <= ram_we;
        m_addr <= ram_addr;
        m_din  <= ram_din;
        if (m_we) mem[m_addr] <= m_din;
        m_dout <= mem[m_addr];
    end
    assign ram_dout = m_dout;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        int            due;
    } exp_rsp_t;

    exp_rsp_t      sb[$];
    logic [DW-1:0] exp_mem [int];
    int            cyc = 0;
    int            exp_ptr = 0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_din = '0;
    int            init_cnt = 0;
    int            gnt_cyc [NREQ];
    int            first_after_rst = -1;
    int            streak = 0;
    int            b2b_max = 0;

    // Monitor: reference round-robin + RAM-drive checks, scoreboard push/pop.
    always @(negedge clk) begin : mon
        logic [NREQ-1:0] exp_rdy, oh;
        int              g, a;
        exp_rsp_t        e;
        cyc++;
        if (rst) begin
            check("rst_ready", req_ready, '0);
            check("rst_rsp_valid", rsp_valid, '0);
            check("rst_ram_we", ram_we, '0);
            check("rst_ram_addr", ram_addr, '0);
            check("rst_ram_din", ram_din, '0);
            check("rst_init_done", init_done, '0);
            sb.delete();
            exp_ptr = 0;
            last_addr = '0;
            last_din = '0;
            init_cnt = 0;
            first_after_rst = -1;
            streak = 0;
        end
`ifdef SP_RAM_ARB_INIT_EN
        else if (init_cnt < DEPTH) begin
            check("init_ready", req_ready, '0);
            check("init_ram_we", ram_we, 1);
            check("init_ram_addr", ram_addr, AW'(init_cnt));
            check("init_ram_din", ram_din, '0);
            check("init_done_low", init_done, '0);
            exp_mem[init_cnt] = '0;
            init_cnt++;
        end
`endif
        else begin
            exp_rdy = '0;
            g = -1;
            for (int off = 0; off < NREQ; off++) begin
                if (g < 0 && req_valid[(exp_ptr + off) % NREQ]) g = (exp_ptr + off) % NREQ;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("ready", req_ready, exp_rdy);
            check("init_done", init_done, 1);
            if (g >= 0) begin
                check("gnt_ram_we", ram_we, req_we[g]);
                check("gnt_ram_addr", ram_addr, req_addr[g]);
                check("gnt_ram_din", ram_din, req_wdata[g]);
                last_addr = req_addr[g];
                last_din = req_wdata[g];
                exp_ptr = (g + 1) % NREQ;
                gnt_cyc[g] = cyc;
                if (first_after_rst < 0) first_after_rst = g;
                a = int'(req_addr[g]);
                if (req_we[g]) begin
                    exp_mem[a] = req_wdata[g];
                end else begin
                    e.idx  = g;
                    e.data = exp_mem.exists(a) ? exp_mem[a] : '0;
                    e.due  = cyc + 2;
                    sb.push_back(e);
                end
            end else begin
                check("idle_ram_we", ram_we, '0);
                check("idle_ram_addr", ram_addr, last_addr);
                check("idle_ram_din", ram_din, last_din);
            end
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, '0);
                end else begin
                    e = sb.pop_front();
                    oh = '0;
                    oh[e.idx] = 1'b1;
                    check("rsp_valid", rsp_valid, oh);
                    check("rsp_rdata", rsp_rdata, e.data);
                    check("rsp_cycle", cyc, e.due);
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                oh = '0;
                oh[e.idx] = 1'b1;
                check("rsp_missing", rsp_valid, oh);
            end
            streak = (rsp_valid == 2'b10) ? streak + 1 : 0;
            if (streak > b2b_max) b2b_max = streak;
        end
    end

    task automatic issue(input int i, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
        int   n;
        logic got;
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = data;
        got = 1'b0;
        n = 0;
        while (!got) begin
            @(negedge clk);
            got = req_ready[i];
            @(posedge clk);
            #1;
            n++;
            if (!got && n >= 64) begin
                check("hs_timeout", got, 1'b1);
                break;
            end
        end
        req_valid[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!init_done && n < DEPTH + 16) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("init_done_up", init_done, 1);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom, $urandom, $urandom});
    endfunction

    int t0;

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        wait_ready();

`ifdef SP_RAM_ARB_INIT_EN
        issue(0, 1'b0, 12'h007, '0);
        idle(4);
`endif

        // Single write then read-after-write.
        issue(0, 1'b1, 12'h010, 82'h2A);
        issue(0, 1'b0, 12'h010, '0);
        idle(4);

        // Contention on reads.
        issue(0, 1'b1, 12'h001, rnd_data());
        issue(0, 1'b1, 12'h002, rnd_data());
        fork
            begin repeat (4) issue(0, 1'b0, 12'h001, '0); end
            begin repeat (4) issue(1, 1'b0, 12'h002, '0); end
        join
        idle(4);

        // Back-to-back reads by requester 1.
        for (int a = 0; a < 16; a++) issue(0, 1'b1, AW'(a), rnd_data());
        for (int a = 0; a < 16; a++) issue(1, 1'b0, AW'(a), '0);
        idle(4);
        check("b2b_streak", b2b_max, 16);

        // Reset one cycle after a read grant; last grant leaves ptr at 1.
        issue(0, 1'b0, 12'h005, '0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        wait_ready();
        idle(3);
        fork
            issue(0, 1'b0, 12'h001, '0);
            issue(1, 1'b0, 12'h002, '0);
        join
        check("rst_first_gnt", first_after_rst, 0);
        idle(4);

        // Backpressure: requester 1 holds a write while requester 0 streams.
        fork
            begin
                for (int j = 0; j < 8; j++) issue(0, 1'b1, AW'(12'h100 + j), rnd_data());
            end
            begin
                idle(2);
                t0 = cyc + 1;
                issue(1, 1'b1, 12'h200, 82'h3_DEAD_BEEF_0123_4567);
                check("bp_wait", (gnt_cyc[1] - t0) <= 1, 1'b1);
            end
        join
        issue(1, 1'b0, 12'h200, '0);
        idle(6);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

endmodule
